// File: rtl/encoder_conv.sv
// ---------------------------------------------------------------------------
// encoder_conv
//   Rate 1/2, K=7 convolutional encoder (g0 = 133 octal -> A, g1 = 171 octal
//   -> B) with a serial bit-in / bit-out interface and optional six-bit zero
//   tail for trellis termination.
//
// Parameters
//   frame  : maximum payload length; a larger Length is clamped to frame.
//   TAIL   : 1 = append six zero tail bits after the payload, 0 = no tail.
//
// Ports
//   Clk     in   single clock, rising edge
//   Reset   in   synchronous active-high reset (highest priority)
//   Start   in   high = frame in progress; low behaves like Reset
//   Length  in   payload bit count, latched on the first cycle of Start
//   x       in   serial payload bit, sampled at edges where Ready is high
//   Ready   out  x is sampled at the end of this cycle
//   Out     out  coded bit (A then B per input bit), 0 when Valid is low
//   Valid   out  Out carries a coded bit
//   Done    out  frame fully emitted; held until Start low or Reset
// ---------------------------------------------------------------------------
module encoder_conv #(
    parameter int frame = 512,
    parameter bit TAIL  = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [14:0] Length,
    input  logic        x,
    output logic        Ready,
    output logic        Out,
    output logic        Valid,
    output logic        Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [14:0] FRAME_LEN = 15'(frame);
    localparam logic [2:0]  TAIL_BITS = 3'd6;

    // Generator g0 = 133 octal: taps on the new bit and sr[1], sr[2], sr[4], sr[5].
    function automatic logic conv_a(input logic bit_in, input logic [5:0] sr);
        return bit_in ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
    endfunction

    // Generator g1 = 171 octal: taps on the new bit and sr[0], sr[1], sr[2], sr[5].
    function automatic logic conv_b(input logic bit_in, input logic [5:0] sr);
        return bit_in ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
    endfunction

    state_t      state_r, state_s;
    logic        phase_r, phase_s;    // 0: feed slot (B of previous bit on Out), 1: A on Out
    logic [14:0] cnt_r,   cnt_s;      // payload bits accepted
    logic [2:0]  tcnt_r,  tcnt_s;     // tail bits fed
    logic [14:0] len_r,   len_s;      // latched, clamped Length
    logic [5:0]  sr_r,    sr_s;
    logic        b_hold_r, b_hold_s;  // B of the bit just fed, emitted one cycle after A

    logic        feed_s;              // a bit enters the encoder at this edge
    logic        feed_bit_s;
    logic        a_s;
    logic        emit_b_s;
    logic [14:0] clamp_len_s;

    logic        ready_s, out_s, valid_s, done_s;

    // State and datapath registers plus registered outputs; Reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= S_IDLE;
            phase_r  <= 1'b0;
            cnt_r    <= 15'd0;
            tcnt_r   <= 3'd0;
            len_r    <= 15'd0;
            sr_r     <= 6'd0;
            b_hold_r <= 1'b0;
            Ready    <= 1'b0;
            Out      <= 1'b0;
            Valid    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            cnt_r    <= cnt_s;
            tcnt_r   <= tcnt_s;
            len_r    <= len_s;
            sr_r     <= sr_s;
            b_hold_r <= b_hold_s;
            Ready    <= ready_s;
            Out      <= out_s;
            Valid    <= valid_s;
            Done     <= done_s;
        end
    end

    // Next-state and datapath: decides which bit (payload, tail or none) is fed this edge.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        cnt_s       = cnt_r;
        tcnt_s      = tcnt_r;
        len_s       = len_r;
        sr_s        = sr_r;
        b_hold_s    = b_hold_r;
        feed_s      = 1'b0;
        feed_bit_s  = 1'b0;
        emit_b_s    = 1'b0;
        clamp_len_s = (Length > FRAME_LEN) ? FRAME_LEN : Length;

        if (!Start) begin
            state_s  = S_IDLE;
            phase_s  = 1'b0;
            cnt_s    = 15'd0;
            tcnt_s   = 3'd0;
            len_s    = 15'd0;
            sr_s     = 6'd0;
            b_hold_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    len_s   = clamp_len_s;
                    phase_s = 1'b0;
                    cnt_s   = 15'd0;
                    tcnt_s  = 3'd0;
                    sr_s    = 6'd0;
                    if (clamp_len_s != 15'd0) begin
                        state_s = S_RUN;
                    end else if (TAIL == 1'b1) begin
                        state_s = S_TAIL;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                S_RUN, S_TAIL: begin
                    if (phase_r == 1'b0) begin
                        // The last B of the payload shares this slot with the first
                        // tail feed, so the coded stream has no gap at the seam.
                        if ((state_r == S_RUN) && (cnt_r < len_r)) begin
                            feed_s     = 1'b1;
                            feed_bit_s = x;
                            cnt_s      = cnt_r + 15'd1;
                        end else if ((TAIL == 1'b1) && (tcnt_r < TAIL_BITS)) begin
                            feed_s     = 1'b1;
                            feed_bit_s = 1'b0;
                            tcnt_s     = tcnt_r + 3'd1;
                            state_s    = S_TAIL;
                        end else begin
                            state_s = S_DONE;
                        end
                        if (feed_s) begin
                            sr_s     = {sr_r[4:0], feed_bit_s};
                            b_hold_s = conv_b(feed_bit_s, sr_r);
                            phase_s  = 1'b1;
                        end else begin
                            phase_s = 1'b0;
                        end
                    end else begin
                        emit_b_s = 1'b1;
                        phase_s  = 1'b0;
                    end
                end
                S_DONE: begin
                    state_s = S_DONE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
        a_s = conv_a(feed_bit_s, sr_r);
    end

    // Output decode, registered next edge: A when a bit is fed, B on the following slot.
    always_comb begin
        ready_s = (state_s == S_RUN) && (phase_s == 1'b0) && (cnt_s < len_s);
        valid_s = feed_s || emit_b_s;
        if (feed_s) begin
            out_s = a_s;
        end else if (emit_b_s) begin
            out_s = b_hold_r;
        end else begin
            out_s = 1'b0;
        end
        done_s  = (state_s == S_DONE);
    end

endmodule

// File: tb/tb_encoder_conv.sv
// Directed bench for encoder_conv: one instance with the tail enabled, one without.
module tb_encoder_conv;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start1, start0;
    logic [14:0] Length;
    logic        x;
    logic        ready1, out1, valid1, done1;
    logic        ready0, out0, valid0, done0;

    int errors = 0;
    int checks = 0;

    // Selected-instance view used by the frame runner.
    bit   sel;
    logic m_ready, m_out, m_valid, m_done;
    assign m_ready = sel ? ready1 : ready0;
    assign m_out   = sel ? out1   : out0;
    assign m_valid = sel ? valid1 : valid0;
    assign m_done  = sel ? done1  : done0;

    // Frame capture results.
    logic [1023:0] x_vec;
    logic [63:0]   stream;
    int nvalid, nready, ones, gap_err, rdy_adj, outz_err, done_cyc;

    always #5 Clk = ~Clk;

    encoder_conv #(.frame(512), .TAIL(1'b1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(start1), .Length(Length), .x(x),
        .Ready(ready1), .Out(out1), .Valid(valid1), .Done(done1)
    );

    encoder_conv #(.frame(512), .TAIL(1'b0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(start0), .Length(Length), .x(x),
        .Ready(ready0), .Out(out0), .Valid(valid0), .Done(done0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    // Raise Start for the selected instance and record the frame until Done or the limit.
    task automatic run_frame(input bit s, input logic [14:0] len, input int limit);
        bit prev_valid, prev_ready;
        sel = s; nvalid = 0; nready = 0; ones = 0; gap_err = 0; rdy_adj = 0;
        outz_err = 0; done_cyc = -1; stream = 64'd0; prev_valid = 1'b0; prev_ready = 1'b0;
        @(negedge Clk);
        Length = len;
        x = 1'b0;
        set_start(1'b1);
        for (int c = 0; c < limit; c++) begin
            @(negedge Clk);
            if (m_valid) begin
                if (nvalid > 0 && !prev_valid) gap_err++;
                stream = {stream[62:0], m_out};
                if (m_out) ones++;
                nvalid++;
            end else if (m_out) begin
                outz_err++;
            end
            if (m_ready) begin
                if (prev_ready) rdy_adj++;
                x = x_vec[nready];
                nready++;
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            if (m_done) begin
                done_cyc = c;
                break;
            end
        end
        Length = 15'h7fff;  // later changes must not matter
    endtask

    task automatic drop_start();
        @(negedge Clk);
        start1 = 1'b0;
        start0 = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start1 = 1'b0; start0 = 1'b0; Length = 15'd0; x = 1'b0; sel = 1'b1;
        x_vec = '0;
        repeat (3) @(negedge Clk);
        check("reset_outs", {ready1, out1, valid1, done1, ready0, out0, valid0, done0}, 64'd0);
        Reset = 1'b0;

        // Impulse response through the tail.
        x_vec = '0; x_vec[0] = 1'b1;
        run_frame(1'b1, 15'd1, 100);
        check("imp_done", (done_cyc >= 0), 64'd1);
        check("imp_nvalid", nvalid, 64'd14);
        check("imp_stream", stream[13:0], 64'b11011111001011);
        check("imp_gaps", gap_err, 64'd0);
        @(negedge Clk);
        check("imp_done_hold", {done1, valid1, ready1}, 64'b100);
        drop_start();

        // All-zero payload: 212 zero coded bits, unbroken.
        x_vec = '0;
        run_frame(1'b1, 15'd100, 400);
        check("zero_nvalid", nvalid, 64'd212);
        check("zero_ones", ones, 64'd0);
        check("zero_gaps", gap_err, 64'd0);
        check("zero_done", (done_cyc >= 0), 64'd1);
        drop_start();

        // Cadence on the no-tail instance, x = 1,0,1,1,0,0,1,0.
        x_vec = '0;
        x_vec[7:0] = 8'b0100_1101;
        run_frame(1'b0, 15'd8, 100);
        check("cad_nvalid", nvalid, 64'd16);
        check("cad_stream", stream[15:0], 64'b1101000110101111);
        check("cad_nready", nready, 64'd8);
        check("cad_ready_adj", rdy_adj, 64'd0);
        check("cad_gaps", gap_err, 64'd0);
        check("cad_outz", outz_err, 64'd0);
        drop_start();

        // Abort after five accepted bits, then an impulse must reproduce exactly.
        x_vec = '1;
        sel = 1'b1; nready = 0;
        @(negedge Clk);
        Length = 15'd20; x = 1'b1; start1 = 1'b1;
        for (int c = 0; c < 40 && nready < 5; c++) begin
            @(negedge Clk);
            if (ready1) nready++;
        end
        check("abort_reached", nready, 64'd5);
        @(negedge Clk);  // fifth bit accepted at the preceding edge
        start1 = 1'b0;
        @(negedge Clk);
        check("abort_outs", {valid1, ready1, done1, out1}, 64'd0);
        x_vec = '0; x_vec[0] = 1'b1;
        run_frame(1'b1, 15'd1, 100);
        check("restart_nvalid", nvalid, 64'd14);
        check("restart_stream", stream[13:0], 64'b11011111001011);
        drop_start();

        // Empty frames.
        run_frame(1'b0, 15'd0, 20);
        check("empty0_done_cyc", done_cyc, 64'd0);
        check("empty0_nvalid", nvalid, 64'd0);
        drop_start();
        run_frame(1'b1, 15'd0, 60);
        check("empty1_nvalid", nvalid, 64'd12);
        check("empty1_ones", ones, 64'd0);
        check("empty1_done", (done_cyc >= 0), 64'd1);
        drop_start();

        // Clamp to frame, then a back-to-back frame after one low cycle.
        x_vec = '0;
        run_frame(1'b1, 15'd600, 1300);
        check("clamp_nvalid", nvalid, 64'd1036);
        check("clamp_nready", nready, 64'd512);
        check("clamp_gaps", gap_err, 64'd0);
        drop_start();
        x_vec = '0; x_vec[1:0] = 2'b11;
        run_frame(1'b1, 15'd2, 100);
        check("b2b_nvalid", nvalid, 64'd16);
        check("b2b_stream", stream[15:0], 64'b1110100011100111);

        // Reset has priority over a frame in progress.
        drop_start();
        x_vec = '1;
        run_frame(1'b1, 15'd50, 10);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_prio", {valid1, ready1, done1, out1}, 64'd0);
        Reset = 1'b0;
        start1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_conv.md
ENCODER_CONV -- requirements
Module: encoder_conv

Interface
REQ-001 Parameter: frame, 512, maximum supported Length; Length above frame is clamped to frame.
REQ-002 Parameter: TAIL, 1, 1 = append six zero tail bits after the payload; 0 = no tail.
REQ-003 Port: Clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: Start  input  1  high = frame in progress; low behaves exactly as Reset.
REQ-006 Port: Length  input  15  number of payload bits in the frame; sampled once, on the first cycle Start is high.
REQ-007 Port: x  input  1  serial payload bit; sampled only on cycles where Ready is high.
REQ-008 Port: Ready  output  1  encoder samples x at this rising edge.
REQ-009 Port: Out  output  1  serial coded bit, first A then B for each input bit.
REQ-010 Port: Valid  output  1  Out carries a coded bit this cycle.
REQ-011 Port: Done  output  1  frame fully emitted; held until Start low or Reset.

Function
REQ-012 Code: rate 1/2, K=7, generators g0=133 octal (A), g1=171 octal (B); 6-bit shift register sr, sr[0] = most recent previous bit.
REQ-013 A = x ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]; B = x ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5]; after each accepted bit sr <= {sr[4:0], x}.
REQ-014 FSM states: IDLE, RUN, TAIL, DONE; IDLE is entered by Reset or Start low.
REQ-015 IDLE -> RUN on first cycle with Start high and latched Length >= 1; IDLE -> TAIL when Length = 0 and TAIL = 1; IDLE -> DONE when Length = 0 and TAIL = 0.
REQ-016 RUN uses a 2-cycle phase toggle: phase 0 has Ready = 1 and x sampled; phase 1 has Ready = 0.
REQ-017 Output latency: A is on Out with Valid = 1 in the cycle after x is sampled; B follows in the next cycle with Valid = 1.
REQ-018 A 15-bit bit counter increments per accepted bit; RUN -> TAIL (TAIL = 1) or RUN -> DONE (TAIL = 0) after bit number Length is accepted, with no idle gap between its B and the next state's first output.
REQ-019 TAIL feeds six zero bits on the same 2-cycle cadence with Ready = 0; TAIL -> DONE after the sixth tail bit's B is emitted.
REQ-020 Valid is continuous from the first A to the last B: exactly 2*(Length + 6*TAIL) consecutive cycles per frame.
REQ-021 Out = 0 whenever Valid = 0.
REQ-022 DONE: Ready = 0, Valid = 0, Done = 1; stays in DONE until Start low or Reset; a new frame requires Start to go low and then high again.
REQ-023 Changes on Length after sampling are ignored; Start low mid-frame aborts with no further Valid the following cycle.

Reset
REQ-024 Reset or Start low: state IDLE, sr = 0, counter = 0, phase = 0; Ready = 0, Out = 0, Valid = 0, Done = 0 in the next cycle.
REQ-025 Reset has priority over Start and over all in-progress activity.

Verification
REQ-026 Impulse: TAIL = 1, Length = 1, x = 1 -> 14 Valid bits 11 01 11 11 00 10 11, then Done = 1.
REQ-027 All zeros: Length = 100, x = 0 -> 212 Valid bits, all 0, Valid never drops mid-frame, Done after the last bit.
REQ-028 Cadence: Length = 8, TAIL = 0 -> Ready high on alternate cycles only, 16 Valid cycles, Out matches a software model of REQ-013.
REQ-029 Abort: Start drops after 5 accepted bits -> next cycle Valid = 0, Ready = 0, Done = 0; a restart with x = 1, Length = 1 reproduces REQ-026 (sr cleared).
REQ-030 Empty: Length = 0, TAIL = 0 -> Done = 1 on the second cycle of Start, no Valid ever; with TAIL = 1 -> 12 zero bits, then Done.
REQ-031 Clamp/back-to-back: Length = 600 with frame = 512 -> 2*(512 + 6) Valid bits; then Start low for 1 cycle, high again -> new frame starts cleanly.
